// File: rtl/qspi_pkg.sv
// qspi_pkg: lane modes, transfer direction and FSM encodings shared by the QSPI target and the fx2qspi master.
package qspi_pkg;
  typedef enum logic [1:0] {MODE_SPI = 2'b00, MODE_DPI = 2'b01, MODE_QPI = 2'b10} qspi_mode_e;
  // Direction named from the master's side: OUT = master writes, IN = master reads.
  typedef enum logic {DIR_OUT = 1'b0, DIR_IN = 1'b1} qspi_dir_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_SHIFT = 2'd2} qspi_state_e;
  function automatic qspi_mode_e decode_mode(input logic [1:0] m);
    return m == 2'b01 ? MODE_DPI : m == 2'b10 ? MODE_QPI : MODE_SPI;
  endfunction
  function automatic logic [2:0] last_edge(input qspi_mode_e m);
    return m == MODE_QPI ? 3'd1 : m == MODE_DPI ? 3'd3 : 3'd7;
  endfunction
endpackage

// File: rtl/qspi_sync_edge.sv
// qspi_sync_edge: multi-flop synchroniser with one-cycle rise/fall pulses taken from the last two stages.
module qspi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= {STAGES{RST_VAL}};
    else s <= {s[STAGES-2:0], d};
  assign q    = s[STAGES-1];
  assign rise = s[STAGES-2] & ~s[STAGES-1];
  assign fall = ~s[STAGES-2] & s[STAGES-1];
endmodule

// File: rtl/qspi_target.sv
// qspi_target: oversampled SPI/DPI/QPI mode-3 responder exchanging bytes over rx/tx valid-ready handshakes.
module qspi_target
  import qspi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        FX_IFCLK,
  input  logic        RST,
  input  logic        SPI_CS,
  input  logic        SPI_CLK,
  input  logic [3:0]  SPI_IO_I,
  output logic [3:0]  SPI_IO_O,
  output logic [3:0]  SPI_IO_OE,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_dir,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        cs_active,
  output logic [11:0] byte_cnt,
  output logic        rx_overrun,
  output logic        tx_underrun
);
  logic cs_sync, cs_rise, cs_fall, clk_sync, clk_rise, clk_fall;
  qspi_state_e state, state_nxt;
  qspi_mode_e act_mode;
  qspi_dir_e act_dir;
  logic [2:0] edge_cnt;
  logic [7:0] sin, sin_nxt, sout, sout_nxt, tx_hold, load_byte;
  logic [3:0] oe_mode;
  logic tx_full, arm, active, rx_en, last, done, load, shift, tx_acc;
  logic unused_ok;
  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(FX_IFCLK), .rst(RST), .d(SPI_CS), .q(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );
  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk (
    .clk(FX_IFCLK), .rst(RST), .d(SPI_CLK), .q(clk_sync), .rise(clk_rise), .fall(clk_fall)
  );
  assign unused_ok = ^{cs_rise, cs_fall, clk_sync};
  always_ff @(posedge FX_IFCLK or posedge RST)
    if (RST) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == ST_IDLE ? (cs_sync ? ST_IDLE : ST_ARM) :
                state == ST_ARM ? ST_SHIFT : (cs_sync ? ST_IDLE : ST_SHIFT);
    arm       = state == ST_ARM;
    active    = state == ST_SHIFT && !cs_sync;
    rx_en     = act_mode == MODE_SPI || act_dir == DIR_OUT;
    last      = edge_cnt == last_edge(act_mode);
    done      = active && clk_rise && last;
    // Byte 0 was already loaded at ARM, so its first fall must not consume another byte.
    load      = arm || (active && clk_fall && edge_cnt == 3'd0 && byte_cnt != 12'd0);
    shift     = active && clk_fall && edge_cnt != 3'd0;
    tx_acc    = tx_valid && !tx_full;
    load_byte = tx_full ? tx_hold : IDLE_BYTE;
    sin_nxt   = !rx_en ? sin :
                act_mode == MODE_QPI ? {sin[3:0], SPI_IO_I} :
                act_mode == MODE_DPI ? {sin[5:0], SPI_IO_I[1:0]} : {sin[6:0], SPI_IO_I[0]};
    sout_nxt  = act_mode == MODE_QPI ? {sout[3:0], 4'h0} :
                act_mode == MODE_DPI ? {sout[5:0], 2'b00} : {sout[6:0], 1'b0};
    SPI_IO_O  = act_mode == MODE_QPI ? sout[7:4] :
                act_mode == MODE_DPI ? {2'b00, sout[7:6]} : {2'b00, sout[7], 1'b0};
    oe_mode   = act_mode == MODE_SPI ? 4'b0010 : act_dir == DIR_OUT ? 4'b0000 :
                act_mode == MODE_DPI ? 4'b0011 : 4'b1111;
    // Raw CS gating releases the bus without waiting for the synchroniser.
    SPI_IO_OE = state == ST_SHIFT && !SPI_CS ? oe_mode : 4'b0000;
    tx_ready  = !tx_full;
    cs_active = !cs_sync;
  end
  always_ff @(posedge FX_IFCLK or posedge RST)
    if (RST) begin
      act_mode    <= MODE_SPI;
      act_dir     <= DIR_OUT;
      edge_cnt    <= 3'd0;
      byte_cnt    <= 12'd0;
      sin         <= 8'h00;
      sout        <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_hold     <= 8'h00;
      tx_full     <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (arm) begin
        act_mode <= decode_mode(cfg_mode);
        act_dir  <= qspi_dir_e'(cfg_dir);
      end
      edge_cnt <= !active ? 3'd0 : clk_rise ? (last ? 3'd0 : edge_cnt + 3'd1) : edge_cnt;
      byte_cnt <= !active ? 12'd0 : done && byte_cnt != 12'hFFF ? byte_cnt + 12'd1 : byte_cnt;
      if (active && clk_rise) sin <= sin_nxt;
      sout <= load ? load_byte : shift ? sout_nxt : sout;
      if (done && rx_en) begin
        rx_data  <= sin_nxt;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      rx_overrun  <= (rx_overrun && !arm) || (done && rx_en && rx_valid && !rx_ready);
      tx_underrun <= (tx_underrun && !arm) || (load && !tx_full);
      if (tx_acc) tx_hold <= tx_data;
      tx_full <= tx_acc || (tx_full && !load);
    end
endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: directed mode-3 master transactions against qspi_target with hand-computed expectations.
module tb_qspi_target;
  localparam int HALF = 6;
  logic FX_IFCLK = 1'b0;
  logic RST, SPI_CS, SPI_CLK, cfg_dir, rx_valid, rx_ready, tx_valid, tx_ready, cs_active;
  logic rx_overrun, tx_underrun;
  logic [3:0] SPI_IO_I, SPI_IO_O, SPI_IO_OE;
  logic [1:0] cfg_mode;
  logic [7:0] rx_data, tx_data;
  logic [11:0] byte_cnt;
  int checks = 0, failures = 0;
  int rx_cnt = 0, oe_cycles = 0;
  logic [7:0] rx_log [64];
  qspi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .FX_IFCLK(FX_IFCLK), .RST(RST), .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK),
    .SPI_IO_I(SPI_IO_I), .SPI_IO_O(SPI_IO_O), .SPI_IO_OE(SPI_IO_OE),
    .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cs_active(cs_active), .byte_cnt(byte_cnt), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
  );
  always #5 FX_IFCLK = ~FX_IFCLK;
  always @(negedge FX_IFCLK) begin
    if (rx_valid && rx_ready) begin
      rx_log[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (SPI_IO_OE != 4'h0) oe_cycles++;
  end
  function automatic logic [32:0] out_vec();
    return {SPI_IO_O, SPI_IO_OE, rx_data, rx_valid, tx_ready, cs_active, byte_cnt, rx_overrun, tx_underrun};
  endfunction
  localparam logic [32:0] RST_VEC = {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
  task automatic cyc(input int n);
    repeat (n) @(negedge FX_IFCLK);
  endtask
  task automatic sel(input logic [1:0] m, input logic d);
    cfg_mode = m;
    cfg_dir = d;
    SPI_CS = 1'b0;
    cyc(6);
  endtask
  task automatic desel;
    SPI_CS = 1'b1;
    cyc(6);
  endtask
  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask
  task automatic xfer(input int b, input logic [7:0] mosi, output logic [7:0] miso);
    logic [7:0] t;
    t = mosi;
    miso = 8'h00;
    for (int e = 0; e < 8 / b; e++) begin
      SPI_CLK = 1'b0;
      SPI_IO_I = b == 4 ? t[7:4] : b == 2 ? {2'b00, t[7:6]} : {3'b000, t[7]};
      cyc(HALF);
      miso = b == 4 ? {miso[3:0], SPI_IO_O} : b == 2 ? {miso[5:0], SPI_IO_O[1:0]} : {miso[6:0], SPI_IO_O[1]};
      t = t << b;
      SPI_CLK = 1'b1;
      cyc(HALF);
    end
  endtask
  task automatic test_reset;
    cyc(3);
    checks++;
    if (out_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", out_vec(), RST_VEC);
    end
  endtask
  task automatic test_spi;
    logic [7:0] ob;
    rx_ready = 1'b0;
    load_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL spi_tx_full got=%b want=0", tx_ready); end
    sel(2'b00, 1'b0);
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL spi_arm_load got=%b want=1", tx_ready); end
    checks++;
    if ({cs_active, SPI_IO_OE} !== 5'b10010) begin failures++; $display("FAIL spi_cs_oe got=%b want=10010", {cs_active, SPI_IO_OE}); end
    xfer(1, 8'h3C, ob);
    cyc(2);
    checks++;
    if (ob !== 8'hA5) begin failures++; $display("FAIL spi_miso got=%h want=a5", ob); end
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL spi_rx got=%b/%h want=1/3c", rx_valid, rx_data); end
    checks++;
    if (byte_cnt !== 12'd1) begin failures++; $display("FAIL spi_byte_cnt got=%0d want=1", byte_cnt); end
    desel;
    rx_ready = 1'b1;
    cyc(2);
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL spi_rx_accept got=%b want=0", rx_valid); end
  endtask
  task automatic test_qpi_rx;
    logic [7:0] ob;
    int base, oe0;
    rx_ready = 1'b1;
    base = rx_cnt;
    oe0 = oe_cycles;
    sel(2'b10, 1'b0);
    xfer(4, 8'h5A, ob);
    xfer(4, 8'hC3, ob);
    checks++;
    if (byte_cnt !== 12'd2) begin failures++; $display("FAIL qpi_byte_cnt got=%0d want=2", byte_cnt); end
    desel;
    checks++;
    if (rx_cnt - base !== 2) begin failures++; $display("FAIL qpi_rx_pulses got=%0d want=2", rx_cnt - base); end
    checks++;
    if (rx_log[base % 64] !== 8'h5A) begin failures++; $display("FAIL qpi_rx0 got=%h want=5a", rx_log[base % 64]); end
    checks++;
    if (rx_log[(base + 1) % 64] !== 8'hC3) begin failures++; $display("FAIL qpi_rx1 got=%h want=c3", rx_log[(base + 1) % 64]); end
    checks++;
    if (oe_cycles - oe0 !== 0) begin failures++; $display("FAIL qpi_oe_cycles got=%0d want=0", oe_cycles - oe0); end
  endtask
  task automatic test_dpi_tx;
    logic [7:0] ob0, ob1;
    rx_ready = 1'b1;
    load_tx(8'h96);
    sel(2'b01, 1'b1);
    checks++;
    if (tx_underrun !== 1'b0) begin failures++; $display("FAIL dpi_underrun_cleared got=%b want=0", tx_underrun); end
    checks++;
    if (SPI_IO_OE !== 4'b0011) begin failures++; $display("FAIL dpi_oe got=%b want=0011", SPI_IO_OE); end
    xfer(2, 8'h00, ob0);
    xfer(2, 8'h00, ob1);
    checks++;
    if (ob0 !== 8'h96) begin failures++; $display("FAIL dpi_byte0 got=%h want=96", ob0); end
    checks++;
    if (ob1 !== 8'hFF) begin failures++; $display("FAIL dpi_idle_byte got=%h want=ff", ob1); end
    checks++;
    if ({tx_underrun, byte_cnt} !== {1'b1, 12'd2}) begin failures++; $display("FAIL dpi_underrun_cnt got=%b/%0d want=1/2", tx_underrun, byte_cnt); end
    desel;
  endtask
  task automatic test_cs_abort;
    logic [7:0] ob;
    rx_ready = 1'b0;
    sel(2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      SPI_CLK = 1'b0;
      SPI_IO_I = 4'h1;
      cyc(HALF);
      SPI_CLK = 1'b1;
      cyc(HALF);
    end
    checks++;
    if (byte_cnt !== 12'd0) begin failures++; $display("FAIL abort_byte_cnt got=%0d want=0", byte_cnt); end
    SPI_CS = 1'b1;
    #1;
    checks++;
    if (SPI_IO_OE !== 4'h0) begin failures++; $display("FAIL abort_oe got=%b want=0000", SPI_IO_OE); end
    cyc(1);
    checks++;
    if (cs_active !== 1'b1) begin failures++; $display("FAIL abort_sync_latency got=%b want=1", cs_active); end
    cyc(2);
    checks++;
    if ({cs_active, rx_valid, byte_cnt} !== 14'd0) begin failures++; $display("FAIL abort_idle got=%b/%b/%0d want=0/0/0", cs_active, rx_valid, byte_cnt); end
    cyc(3);
    sel(2'b00, 1'b0);
    xfer(1, 8'h81, ob);
    cyc(2);
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h81}) begin failures++; $display("FAIL abort_fresh_rx got=%b/%h want=1/81", rx_valid, rx_data); end
    desel;
    rx_ready = 1'b1;
    cyc(2);
  endtask
  task automatic test_overrun;
    logic [7:0] ob;
    rx_ready = 1'b0;
    sel(2'b00, 1'b0);
    xfer(1, 8'h11, ob);
    xfer(1, 8'h22, ob);
    cyc(2);
    checks++;
    if ({rx_valid, rx_overrun, rx_data} !== {1'b1, 1'b1, 8'h22}) begin failures++; $display("FAIL overrun got=%b/%b/%h want=1/1/22", rx_valid, rx_overrun, rx_data); end
    desel;
    checks++;
    if (rx_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b want=1", rx_overrun); end
    sel(2'b00, 1'b0);
    checks++;
    if ({rx_overrun, rx_valid} !== 2'b01) begin failures++; $display("FAIL overrun_clear got=%b want=01", {rx_overrun, rx_valid}); end
    desel;
    rx_ready = 1'b1;
    cyc(2);
  endtask
  task automatic test_rst_mid;
    logic [7:0] ob;
    load_tx(8'hA5);
    sel(2'b10, 1'b1);
    checks++;
    if (SPI_IO_OE !== 4'b1111) begin failures++; $display("FAIL qpi_read_oe got=%b want=1111", SPI_IO_OE); end
    SPI_CLK = 1'b0;
    cyc(HALF);
    SPI_CLK = 1'b1;
    cyc(2);
    RST = 1'b1;
    cyc(1);
    checks++;
    if (out_vec() !== RST_VEC) begin failures++; $display("FAIL rst_mid got=%h want=%h", out_vec(), RST_VEC); end
    SPI_CS = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(3);
    load_tx(8'hE7);
    sel(2'b10, 1'b1);
    xfer(4, 8'h00, ob);
    checks++;
    if (ob !== 8'hE7) begin failures++; $display("FAIL rst_fresh_tx got=%h want=e7", ob); end
    checks++;
    if (byte_cnt !== 12'd1) begin failures++; $display("FAIL rst_fresh_cnt got=%0d want=1", byte_cnt); end
    desel;
  endtask
  initial begin
    RST = 1'b1;
    SPI_CS = 1'b1;
    SPI_CLK = 1'b1;
    SPI_IO_I = 4'h0;
    cfg_mode = 2'b00;
    cfg_dir = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    test_reset;
    RST = 1'b0;
    cyc(2);
    test_spi;
    test_qpi_rx;
    test_dpi_tx;
    test_cs_abort;
    test_overrun;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
